// File: rtl/cve2_pkg.sv
// Shared types for the FP writeback buffer: exception flag layout and buffer entry format.
package cve2_pkg;

  localparam int unsigned FPWB_DEPTH_DEFAULT = 32'd2;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } fflags_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic        rd_fp;
    logic [31:0] data;
    fflags_t     flags;
    logic        done;
  } fpwb_entry_t;

endpackage

// File: rtl/cve2_fp_wb_buffer.sv
// In-order FPU writeback buffer: pairs results with destinations, commits to the register files,
// accumulates fflags. Define CVE2_FPWB_BYPASS_EN to let a result at the head write back in its fill cycle.
module cve2_fp_wb_buffer
  import cve2_pkg::*;
#(
  parameter int unsigned DEPTH = FPWB_DEPTH_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        issue_valid_i,
  output logic        issue_ready_o,
  input  logic [4:0]  issue_rd_i,
  input  logic        issue_rd_fp_i,
  input  logic        fpu_valid_i,
  output logic        fpu_ready_o,
  input  logic [31:0] fpu_result_i,
  input  logic [4:0]  fpu_status_i,
  input  logic        flush_i,
  input  logic        wb_int_busy_i,
  output logic        wb_valid_o,
  output logic [4:0]  wb_rd_o,
  output logic        wb_fp_o,
  output logic [31:0] wb_data_o,
  output logic [4:0]  fflags_o,
  input  logic        fflags_we_i,
  input  logic [4:0]  fflags_wdata_i,
  output logic [31:0] pend_int_o,
  output logic [31:0] pend_fp_o,
  output logic        busy_o,
  output logic        err_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned PTR_W = IDX_W + 32'd1;

  fpwb_entry_t      mem_r [DEPTH];
  logic [PTR_W-1:0] alloc_ptr_r;
  logic [PTR_W-1:0] fill_ptr_r;
  logic [PTR_W-1:0] head_ptr_r;
  fflags_t          fflags_r;
  logic             err_r;

  logic [PTR_W-1:0] count_s;
  logic             full_s;
  logic             issue_fire_s;
  logic             fill_fire_s;
  logic             commit_s;
  logic             bypass_s;
  logic             port_free_s;
  logic [IDX_W-1:0] alloc_idx_s;
  logic [IDX_W-1:0] fill_idx_s;
  logic [IDX_W-1:0] head_idx_s;
  logic [IDX_W-1:0] off_s;
  logic             live_s;
  fpwb_entry_t      head_s;
  fflags_t          commit_flags_s;
  fflags_t          fflags_base_s;
  fflags_t          fflags_next_s;
  logic [31:0]      pend_int_s;
  logic [31:0]      pend_fp_s;

  assign alloc_idx_s  = alloc_ptr_r[IDX_W-1:0];
  assign fill_idx_s   = fill_ptr_r[IDX_W-1:0];
  assign head_idx_s   = head_ptr_r[IDX_W-1:0];
  assign count_s      = alloc_ptr_r - head_ptr_r;
  assign full_s       = (count_s == PTR_W'(DEPTH));
  assign head_s       = mem_r[head_idx_s];

  assign issue_ready_o = ~full_s;
  assign fpu_ready_o   = (fill_ptr_r != alloc_ptr_r);
  assign busy_o        = (head_ptr_r != alloc_ptr_r);
  assign issue_fire_s  = issue_valid_i & ~full_s;
  assign fill_fire_s   = fpu_valid_i & fpu_ready_o;
  assign port_free_s   = head_s.rd_fp | ~wb_int_busy_i;
  assign commit_s      = wb_valid_o;

  assign fflags_o   = fflags_r;
  assign err_o      = err_r;
  assign pend_int_o = pend_int_s;
  assign pend_fp_o  = pend_fp_s;

  // Head-of-buffer write port, optionally fed straight from the FPU when the head is being filled.
  always_comb begin
    wb_rd_o        = head_s.rd;
    wb_fp_o        = head_s.rd_fp;
    wb_data_o      = head_s.data;
    commit_flags_s = head_s.flags;
    bypass_s       = 1'b0;
    wb_valid_o     = 1'b0;
`ifdef CVE2_FPWB_BYPASS_EN
    if (fill_fire_s && (fill_ptr_r == head_ptr_r) && port_free_s) begin
      bypass_s       = 1'b1;
      wb_valid_o     = 1'b1;
      wb_data_o      = fpu_result_i;
      commit_flags_s = fflags_t'(fpu_status_i);
    end else begin
      wb_valid_o = busy_o & head_s.done & port_free_s;
    end
`else
    wb_valid_o = busy_o & head_s.done & port_free_s;
`endif
  end

  // Sticky flag merge; a CSR write replaces the old value but never masks a same-cycle commit.
  always_comb begin
    if (fflags_we_i) begin
      fflags_base_s = fflags_t'(fflags_wdata_i);
    end else begin
      fflags_base_s = fflags_r;
    end
    if (commit_s) begin
      fflags_next_s = fflags_t'(fflags_base_s | commit_flags_s);
    end else begin
      fflags_next_s = fflags_base_s;
    end
  end

  // Pending-destination masks over every live entry, filled or not.
  always_comb begin
    pend_int_s = 32'd0;
    pend_fp_s  = 32'd0;
    off_s      = '0;
    live_s     = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      off_s  = IDX_W'(i) - head_idx_s;
      live_s = ({1'b0, off_s} < count_s);
      pend_fp_s[mem_r[i].rd]  = pend_fp_s[mem_r[i].rd] | (live_s & mem_r[i].rd_fp);
      pend_int_s[mem_r[i].rd] = pend_int_s[mem_r[i].rd] | (live_s & ~mem_r[i].rd_fp);
    end
    pend_int_s[0] = 1'b0;
  end

  // Pointers, sticky flags and the orphan-result error pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      alloc_ptr_r <= '0;
      fill_ptr_r  <= '0;
      head_ptr_r  <= '0;
      fflags_r    <= '0;
      err_r       <= 1'b0;
    end else begin
      fflags_r <= fflags_next_s;
      err_r    <= fpu_valid_i & ~fpu_ready_o;
      if (flush_i) begin
        alloc_ptr_r <= '0;
        fill_ptr_r  <= '0;
        head_ptr_r  <= '0;
      end else begin
        if (issue_fire_s) begin
          alloc_ptr_r <= alloc_ptr_r + PTR_W'(1);
        end
        if (fill_fire_s) begin
          fill_ptr_r <= fill_ptr_r + PTR_W'(1);
        end
        if (commit_s) begin
          head_ptr_r <= head_ptr_r + PTR_W'(1);
        end
      end
    end
  end

  // Entry storage; a bypassed result is consumed immediately and never marked done.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_r[i] <= '0;
      end
    end else if (!flush_i) begin
      if (fill_fire_s) begin
        mem_r[fill_idx_s].data  <= fpu_result_i;
        mem_r[fill_idx_s].flags <= fflags_t'(fpu_status_i);
        mem_r[fill_idx_s].done  <= ~bypass_s;
      end
      if (issue_fire_s) begin
        mem_r[alloc_idx_s].rd    <= issue_rd_i;
        mem_r[alloc_idx_s].rd_fp <= issue_rd_fp_i;
        mem_r[alloc_idx_s].done  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cve2_fp_wb_buffer.sv
// Bench for cve2_fp_wb_buffer: directed vector table, corner sequences, and random traffic vs a queue model.
module tb_cve2_fp_wb_buffer;
  import cve2_pkg::*;

  localparam int DEPTH = 2;
`ifdef CVE2_FPWB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_i, issue_valid_i, issue_ready_o, issue_rd_fp_i;
  logic [4:0]  issue_rd_i;
  logic        fpu_valid_i, fpu_ready_o, flush_i, wb_int_busy_i;
  logic [31:0] fpu_result_i;
  logic [4:0]  fpu_status_i;
  logic        wb_valid_o, wb_fp_o;
  logic [4:0]  wb_rd_o, fflags_o, fflags_wdata_i;
  logic [31:0] wb_data_o, pend_int_o, pend_fp_o;
  logic        fflags_we_i, busy_o, err_o;

  int checks = 0;
  int errors = 0;

  cve2_fp_wb_buffer #(.DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .issue_rd_i(issue_rd_i), .issue_rd_fp_i(issue_rd_fp_i),
    .fpu_valid_i(fpu_valid_i), .fpu_ready_o(fpu_ready_o),
    .fpu_result_i(fpu_result_i), .fpu_status_i(fpu_status_i),
    .flush_i(flush_i), .wb_int_busy_i(wb_int_busy_i),
    .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o), .wb_fp_o(wb_fp_o), .wb_data_o(wb_data_o),
    .fflags_o(fflags_o), .fflags_we_i(fflags_we_i), .fflags_wdata_i(fflags_wdata_i),
    .pend_int_o(pend_int_o), .pend_fp_o(pend_fp_o), .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  task automatic clr();
    issue_valid_i = 1'b0; issue_rd_i = 5'd0; issue_rd_fp_i = 1'b0;
    fpu_valid_i = 1'b0; fpu_result_i = 32'd0; fpu_status_i = 5'd0;
    flush_i = 1'b0; wb_int_busy_i = 1'b0; fflags_we_i = 1'b0; fflags_wdata_i = 5'd0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic iv; logic [4:0] ird; logic ifp; logic fv; logic [31:0] res; logic [4:0] st;
    logic ib; logic fwe; logic [4:0] fwd;
    logic wbv; logic [4:0] wrd; logic [31:0] wdat; logic [4:0] ff;
    logic [31:0] pi; logic [31:0] pf; logic bsy; logic ir; logic fr; logic er;
  } vec_t;

  function automatic vec_t v(input logic iv, input logic [4:0] ird, input logic ifp,
                             input logic fv, input logic [31:0] res, input logic [4:0] st,
                             input logic ib, input logic fwe, input logic [4:0] fwd,
                             input logic wbv, input logic [4:0] wrd, input logic [31:0] wdat,
                             input logic [4:0] ff, input logic [31:0] pi, input logic [31:0] pf,
                             input logic bsy, input logic ir, input logic fr, input logic er);
    vec_t r;
    r.iv = iv; r.ird = ird; r.ifp = ifp; r.fv = fv; r.res = res; r.st = st;
    r.ib = ib; r.fwe = fwe; r.fwd = fwd; r.wbv = wbv; r.wrd = wrd; r.wdat = wdat;
    r.ff = ff; r.pi = pi; r.pf = pf; r.bsy = bsy; r.ir = ir; r.fr = fr; r.er = er;
    return r;
  endfunction

  typedef struct {
    logic [4:0] rd; logic fp; logic [31:0] data; logic [4:0] fl; logic done;
  } ment_t;

  ment_t       q[$];
  int          nf;
  logic [4:0]  mflags;
  logic        merr;

  localparam int NV = 23;
  vec_t tbl [NV];

  initial begin
    tbl[0]  = v(1'b1, 5'd5, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 5'd0,  1'b0, 5'd0, 32'h0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    tbl[1]  = v(1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 5'd0,  1'b0, 5'd0, 32'h0, 5'd0, 32'h20, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0);
    tbl[2]  = v(1'b0, 5'd0, 1'b0, 1'b1, 32'h3F800000, 5'd1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 5'd0, 32'h20, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0);
    tbl[3]  = v(1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 5'd0,  1'b1, 5'd5, 32'h3F800000, 5'd0, 32'h20, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    tbl[4]  = v(1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 5'd0,  1'b0, 5'd0, 32'h0, 5'd1, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    tbl[5]  = v(1'b1, 5'd1, 1'b1, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 5'd0,  1'b0, 5'd0, 32'h0, 5'd1, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    tbl[6]  = v(1'b1, 5'd2, 1'b1, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 5'd0,  1'b0, 5'd0, 32'h0, 5'd1, 32'h0, 32'h2, 1'b1, 1'b1, 1'b1, 1'b0);
    tbl[7]  = v(1'b0, 5'd0, 1'b0, 1'b1, 32'hA5A50001, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 5'd1, 32'h0, 32'h6, 1'b1, 1'b0, 1'b1, 1'b0);
    tbl[8]  = v(1'b0, 5'd0, 1'b0, 1'b1, 32'h5A5A0002, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 5'd1, 32'hA5A50001, 5'd1, 32'h0, 32'h6, 1'b1, 1'b0, 1'b1, 1'b0);
    tbl[9]  = v(1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 5'd0, 1'b1, 1'b0, 5'd0,  1'b1, 5'd2, 32'h5A5A0002, 5'd1, 32'h0, 32'h4, 1'b1, 1'b1, 1'b0, 1'b0);
    tbl[10] = v(1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 5'd0,  1'b0, 5'd0, 32'h0, 5'd1, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    tbl[11] = v(1'b1, 5'd3, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 5'd0,  1'b0, 5'd0, 32'h0, 5'd1, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    tbl[12] = v(1'b0, 5'd0, 1'b0, 1'b1, 32'hC0DE0003, 5'b01000, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 5'd1, 32'h8, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0);
    tbl[13] = v(1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b1, 5'd0,  1'b1, 5'd3, 32'hC0DE0003, 5'd1, 32'h8, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    tbl[14] = v(1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 5'd0,  1'b0, 5'd0, 32'h0, 5'b01000, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    tbl[15] = v(1'b1, 5'd0, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 5'd0,  1'b0, 5'd0, 32'h0, 5'b01000, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    tbl[16] = v(1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 5'd0,  1'b0, 5'd0, 32'h0, 5'b01000, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0);
    tbl[17] = v(1'b0, 5'd0, 1'b0, 1'b1, 32'hDDDD0004, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 5'b01000, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0);
    tbl[18] = v(1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 5'd0,  1'b1, 5'd0, 32'hDDDD0004, 5'b01000, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    tbl[19] = v(1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 5'd0,  1'b0, 5'd0, 32'h0, 5'b01000, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    tbl[20] = v(1'b0, 5'd0, 1'b0, 1'b1, 32'h0, 5'd0, 1'b0, 1'b0, 5'd0,  1'b0, 5'd0, 32'h0, 5'b01000, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    tbl[21] = v(1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 5'd0,  1'b0, 5'd0, 32'h0, 5'b01000, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
    tbl[22] = v(1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 5'd0,  1'b0, 5'd0, 32'h0, 5'b01000, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    if (BYP) begin
      // A result landing on the head writes back in its fill cycle.
      tbl[2].wbv = 1'b1; tbl[2].wrd = 5'd5; tbl[2].wdat = 32'h3F800000;
      tbl[3].wbv = 1'b0; tbl[3].ff = 5'd1; tbl[3].pi = 32'h0; tbl[3].bsy = 1'b0; tbl[3].fr = 1'b0;
      tbl[7].wbv = 1'b1; tbl[7].wrd = 5'd1; tbl[7].wdat = 32'hA5A50001;
      tbl[8].wbv = 1'b1; tbl[8].wrd = 5'd2; tbl[8].wdat = 32'h5A5A0002;
      tbl[8].pf = 32'h4; tbl[8].ir = 1'b1;
      tbl[9].wbv = 1'b0; tbl[9].pf = 32'h0; tbl[9].bsy = 1'b0; tbl[9].fr = 1'b0;
    end

    clr();
    rst_i = 1'b1;
    step();
    step();
    rst_i = 1'b0;
    #2;
    chk("rst.busy", 32'(busy_o), 32'd0);
    chk("rst.issue_ready", 32'(issue_ready_o), 32'd1);
    chk("rst.fpu_ready", 32'(fpu_ready_o), 32'd0);
    chk("rst.wb_valid", 32'(wb_valid_o), 32'd0);
    chk("rst.wb_rd", 32'(wb_rd_o), 32'd0);
    chk("rst.wb_fp", 32'(wb_fp_o), 32'd0);
    chk("rst.wb_data", wb_data_o, 32'd0);
    chk("rst.fflags", 32'(fflags_o), 32'd0);
    chk("rst.pend_int", pend_int_o, 32'd0);
    chk("rst.pend_fp", pend_fp_o, 32'd0);
    chk("rst.err", 32'(err_o), 32'd0);
    step();

    for (int i = 0; i < NV; i++) begin
      clr();
      issue_valid_i = tbl[i].iv; issue_rd_i = tbl[i].ird; issue_rd_fp_i = tbl[i].ifp;
      fpu_valid_i = tbl[i].fv; fpu_result_i = tbl[i].res; fpu_status_i = tbl[i].st;
      wb_int_busy_i = tbl[i].ib; fflags_we_i = tbl[i].fwe; fflags_wdata_i = tbl[i].fwd;
      #2;
      chk($sformatf("vec%0d.wb_valid", i), 32'(wb_valid_o), 32'(tbl[i].wbv));
      if (tbl[i].wbv) begin
        chk($sformatf("vec%0d.wb_rd", i), 32'(wb_rd_o), 32'(tbl[i].wrd));
        chk($sformatf("vec%0d.wb_data", i), wb_data_o, tbl[i].wdat);
      end
      chk($sformatf("vec%0d.fflags", i), 32'(fflags_o), 32'(tbl[i].ff));
      chk($sformatf("vec%0d.pend_int", i), pend_int_o, tbl[i].pi);
      chk($sformatf("vec%0d.pend_fp", i), pend_fp_o, tbl[i].pf);
      chk($sformatf("vec%0d.busy", i), 32'(busy_o), 32'(tbl[i].bsy));
      chk($sformatf("vec%0d.issue_ready", i), 32'(issue_ready_o), 32'(tbl[i].ir));
      chk($sformatf("vec%0d.fpu_ready", i), 32'(fpu_ready_o), 32'(tbl[i].fr));
      chk($sformatf("vec%0d.err", i), 32'(err_o), 32'(tbl[i].er));
      step();
    end

    // Integer head stalled by a busy integer port for three cycles.
    clr(); issue_valid_i = 1'b1; issue_rd_i = 5'd9; step();
    clr(); step();
    clr(); fpu_valid_i = 1'b1; fpu_result_i = 32'hE0E0E0E0; wb_int_busy_i = 1'b1; #2;
    chk("stall.fill_wb_valid", 32'(wb_valid_o), 32'd0);
    step();
    for (int k = 0; k < 3; k++) begin
      clr(); wb_int_busy_i = 1'b1; #2;
      chk($sformatf("stall%0d.wb_valid", k), 32'(wb_valid_o), 32'd0);
      chk($sformatf("stall%0d.pend9", k), 32'(pend_int_o[9]), 32'd1);
      step();
    end
    clr(); #2;
    chk("stall.commit_valid", 32'(wb_valid_o), 32'd1);
    chk("stall.commit_rd", 32'(wb_rd_o), 32'd9);
    chk("stall.commit_data", wb_data_o, 32'hE0E0E0E0);
    chk("stall.pend9_commit", 32'(pend_int_o[9]), 32'd1);
    step();
    clr(); #2;
    chk("stall.pend_after", pend_int_o, 32'd0);
    step();

    // Flush with a committing head and a second pending entry.
    clr(); issue_valid_i = 1'b1; issue_rd_i = 5'd4; step();
    clr(); issue_valid_i = 1'b1; issue_rd_i = 5'd6; issue_rd_fp_i = 1'b1; step();
    clr(); fpu_valid_i = 1'b1; fpu_result_i = 32'hF1F1F1F1; fpu_status_i = 5'b10000;
    wb_int_busy_i = 1'b1; step();
    clr(); flush_i = 1'b1; #2;
    chk("flush.wb_valid", 32'(wb_valid_o), 32'd1);
    chk("flush.wb_rd", 32'(wb_rd_o), 32'd4);
    chk("flush.pend_fp", pend_fp_o, 32'h40);
    step();
    clr(); fpu_valid_i = 1'b1; fpu_result_i = 32'h1; #2;
    chk("flush.busy", 32'(busy_o), 32'd0);
    chk("flush.pend_int", pend_int_o, 32'd0);
    chk("flush.pend_fp", pend_fp_o, 32'd0);
    chk("flush.fpu_ready", 32'(fpu_ready_o), 32'd0);
    chk("flush.fflags", 32'(fflags_o), 32'h18);
    step();
    clr(); #2;
    chk("flush.late_err", 32'(err_o), 32'd1);
    step();

    // Fill latency into an empty buffer with and without bypass.
    clr(); issue_valid_i = 1'b1; issue_rd_i = 5'd10; issue_rd_fp_i = 1'b1; step();
    clr(); step();
    clr(); fpu_valid_i = 1'b1; fpu_result_i = 32'h12345678; #2;
    chk("lat.wb_valid_M", 32'(wb_valid_o), 32'(BYP));
    step();
    clr(); #2;
    chk("lat.wb_valid_M1", 32'(wb_valid_o), 32'(!BYP));
    step();
    clr(); #2;
    chk("lat.busy_after", 32'(busy_o), 32'd0);
    step();

    // Random traffic against a queue-level model.
    clr(); rst_i = 1'b1; step(); rst_i = 1'b0;
    q.delete(); nf = 0; mflags = 5'd0; merr = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] epi, epf;
      logic efr, pfree, byp, ewbv, full;
      logic [4:0] cfl, nfl;
      clr();
      rst_i = ($urandom_range(0, 299) == 0);
      flush_i = ($urandom_range(0, 39) == 0);
      full = (q.size() == DEPTH);
      issue_valid_i = !full && ($urandom_range(0, 1) == 1);
      issue_rd_i = 5'($urandom_range(0, 7));
      issue_rd_fp_i = 1'($urandom_range(0, 1));
      efr = (nf < q.size());
      fpu_valid_i = efr ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 15) == 0);
      fpu_result_i = $urandom;
      fpu_status_i = 5'($urandom_range(0, 31));
      wb_int_busy_i = ($urandom_range(0, 2) == 0);
      fflags_we_i = ($urandom_range(0, 15) == 0);
      fflags_wdata_i = 5'($urandom_range(0, 31));
      #2;
      epi = 32'd0; epf = 32'd0;
      foreach (q[k]) begin
        if (q[k].fp) epf[q[k].rd] = 1'b1;
        else if (q[k].rd != 5'd0) epi[q[k].rd] = 1'b1;
      end
      pfree = (q.size() > 0) && (q[0].fp || !wb_int_busy_i);
      byp = BYP && fpu_valid_i && efr && (nf == 0) && pfree;
      ewbv = byp || (pfree && q[0].done);
      cfl = byp ? fpu_status_i : ((q.size() > 0) ? q[0].fl : 5'd0);
      chk($sformatf("rnd%0d.wb_valid", c), 32'(wb_valid_o), 32'(ewbv));
      if (ewbv) begin
        chk($sformatf("rnd%0d.wb_rd", c), 32'(wb_rd_o), 32'(q[0].rd));
        chk($sformatf("rnd%0d.wb_fp", c), 32'(wb_fp_o), 32'(q[0].fp));
        chk($sformatf("rnd%0d.wb_data", c), wb_data_o, byp ? fpu_result_i : q[0].data);
      end
      chk($sformatf("rnd%0d.fflags", c), 32'(fflags_o), 32'(mflags));
      chk($sformatf("rnd%0d.pend_int", c), pend_int_o, epi);
      chk($sformatf("rnd%0d.pend_fp", c), pend_fp_o, epf);
      chk($sformatf("rnd%0d.busy", c), 32'(busy_o), 32'(q.size() != 0));
      chk($sformatf("rnd%0d.issue_ready", c), 32'(issue_ready_o), 32'(!full));
      chk($sformatf("rnd%0d.fpu_ready", c), 32'(fpu_ready_o), 32'(efr));
      chk($sformatf("rnd%0d.err", c), 32'(err_o), 32'(merr));
      step();
      if (rst_i) begin
        q.delete(); nf = 0; mflags = 5'd0; merr = 1'b0;
      end else begin
        merr = fpu_valid_i && !efr;
        nfl = fflags_we_i ? fflags_wdata_i : mflags;
        mflags = ewbv ? (nfl | cfl) : nfl;
        if (flush_i) begin
          q.delete(); nf = 0;
        end else begin
          if (fpu_valid_i && efr) begin
            q[nf].data = fpu_result_i; q[nf].fl = fpu_status_i; q[nf].done = 1'b1; nf++;
          end
          if (ewbv) begin
            void'(q.pop_front()); nf--;
          end
          if (issue_valid_i && !full) begin
            ment_t e;
            e.rd = issue_rd_i; e.fp = issue_rd_fp_i; e.data = 32'd0; e.fl = 5'd0; e.done = 1'b0;
            q.push_back(e);
          end
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
